// File: rtl/bram_writer_interface_if.sv
// Producer-side and DMA-write-side signal bundle for bram_writer_interface.
// master: the environment (capture logic + DMA engine); slave: the buffer/writer.
interface bram_writer_interface_if #(
    parameter int WORD_WID     = 20,
    parameter int RAM_WID      = 32,
    parameter int RAM_WORD_WID = 16
);
    logic [WORD_WID-1:0]     word_in;
    logic                    word_valid;
    logic                    word_ready;
    logic                    word_full;
    logic                    word_rst;
    logic                    flush_start;
    logic [RAM_WID-1:0]      start_addr;
    logic                    flush_finished;
    logic [RAM_WID-1:0]      ram_dma_addr;
    logic [RAM_WORD_WID-1:0] ram_word;
    logic                    ram_write;
    logic                    ram_write_done;

    modport master (
        output word_in, word_valid, word_rst, flush_start, start_addr, ram_write_done,
        input  word_ready, word_full, flush_finished, ram_dma_addr, ram_word, ram_write
    );

    modport slave (
        input  word_in, word_valid, word_rst, flush_start, start_addr, ram_write_done,
        output word_ready, word_full, flush_finished, ram_dma_addr, ram_word, ram_write
    );
endinterface

// File: rtl/bram_writer_interface.sv
// Sample buffer that captures producer samples into block RAM and, on request,
// writes each sample to main RAM as two DMA words (low half, then sign-extended
// high half) at consecutive addresses.
module bram_writer_interface #(
    parameter int WORD_WID      = 20,
    parameter int WORD_AMNT_WID = 11,
    parameter int WORD_AMNT     = 2047,
    parameter int RAM_WID       = 32,
    parameter int RAM_WORD_WID  = 16,
    parameter int RAM_WORD_INCR = 2
) (
    input logic clk,
    input logic rst,
    bram_writer_interface_if.slave bus
);
    // One extra bit so that a completely full buffer count is representable.
    localparam int CNT_WID = WORD_AMNT_WID + 1;
    localparam int HI_WID  = WORD_WID - RAM_WORD_WID;
    localparam logic [CNT_WID-1:0] FULL_COUNT = CNT_WID'(WORD_AMNT + 1);
    localparam logic [CNT_WID-1:0] CNT_ONE    = CNT_WID'(1);
    localparam logic [RAM_WID-1:0] ADDR_INCR  = RAM_WID'(RAM_WORD_INCR);

    typedef enum logic [2:0] {IDLE, FETCH, WR_LO, GAP, WR_HI, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [CNT_WID-1:0]      count_reg, count_next;
    logic [CNT_WID-1:0]      idx_reg, idx_next;
    logic [RAM_WID-1:0]      addr_reg, addr_next;
    logic                    ram_write_reg, ram_write_next;

    logic [WORD_WID-1:0]      mem [0:WORD_AMNT];
    logic [WORD_WID-1:0]      rd_data_reg;
    logic [WORD_AMNT_WID-1:0] mem_addr;
    logic                     mem_we;
    logic                     accept;
    logic                     word_full;
    logic [RAM_WORD_WID-1:0]  lo_word;
    logic [RAM_WORD_WID-1:0]  hi_word;

    assign word_full      = (count_reg == FULL_COUNT);
    assign bus.word_full  = word_full;
    assign bus.word_ready = (state_reg == IDLE) && !word_full;
    assign accept         = bus.word_valid && bus.word_ready;

    // Single port: filling owns the address in IDLE, flushing owns it otherwise.
    // word_rst wins over a simultaneous accept, so that sample is not stored.
    assign mem_we   = accept && !bus.word_rst;
    assign mem_addr = (state_reg == IDLE) ? count_reg[WORD_AMNT_WID-1:0]
                                          : idx_reg[WORD_AMNT_WID-1:0];

    // Sample buffer with registered read; the read address is held at idx while
    // a sample is being written out, so rd_data_reg stays stable throughout.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= bus.word_in;
        end
        rd_data_reg <= mem[mem_addr];
    end

    assign lo_word = rd_data_reg[RAM_WORD_WID-1:0];

    generate
        if (HI_WID == RAM_WORD_WID) begin : g_hi_full
            assign hi_word = rd_data_reg[WORD_WID-1:RAM_WORD_WID];
        end else begin : g_hi_ext
            assign hi_word = {{(RAM_WORD_WID-HI_WID){rd_data_reg[WORD_WID-1]}},
                              rd_data_reg[WORD_WID-1:RAM_WORD_WID]};
        end
    endgenerate

    // Data is only driven while a sample is in flight; zero otherwise.
    assign bus.ram_word = (state_reg == WR_LO) ? lo_word :
                          ((state_reg == GAP) || (state_reg == WR_HI)) ? hi_word :
                          '0;
    assign bus.ram_write      = ram_write_reg;
    assign bus.ram_dma_addr   = addr_reg;
    assign bus.flush_finished = (state_reg == DONE);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            idx_reg       <= '0;
            addr_reg      <= '0;
            ram_write_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            idx_reg       <= idx_next;
            addr_reg      <= addr_next;
            ram_write_reg <= ram_write_next;
        end
    end

    // Next-state logic: fill in IDLE, then walk the buffer two DMA words per sample.
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        idx_next       = idx_reg;
        addr_next      = addr_reg;
        ram_write_next = ram_write_reg;
        case (state_reg)
            IDLE: begin
                if (bus.word_rst) begin
                    count_next = '0;
                end else if (accept) begin
                    count_next = count_reg + CNT_ONE;
                end
                if (bus.flush_start) begin
                    addr_next  = bus.start_addr;
                    idx_next   = '0;
                    state_next = (count_reg == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                ram_write_next = 1'b1;
                state_next     = WR_LO;
            end
            WR_LO: begin
                if (bus.ram_write_done) begin
                    ram_write_next = 1'b0;
                    addr_next      = addr_reg + ADDR_INCR;
                    state_next     = GAP;
                end
            end
            GAP: begin
                ram_write_next = 1'b1;
                state_next     = WR_HI;
            end
            WR_HI: begin
                if (bus.ram_write_done) begin
                    ram_write_next = 1'b0;
                    addr_next      = addr_reg + ADDR_INCR;
                    idx_next       = idx_reg + CNT_ONE;
                    state_next     = (idx_reg == count_reg - CNT_ONE) ? DONE : FETCH;
                end
            end
            DONE: begin
                if (!bus.flush_start) begin
                    count_next = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule
